frame_stream_tx: RTL



---
 rtl/frame_stream_tx_pkg.sv | 19 +
 rtl/frame_tx_hold_fifo.sv | 55 +++++
 rtl/frame_stream_tx.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/frame_stream_tx_pkg.sv
// Shared types and constants for the frame stream transmitter.
package frame_stream_tx_pkg;

  // Frame sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } tx_state_e;

  // Holding FIFO geometry (depth must stay a power of two for pointer wrap)
  localparam int unsigned HOLD_DEPTH = 2;
  localparam int unsigned HOLD_PTR_W = $clog2(HOLD_DEPTH);
  localparam int unsigned HOLD_CNT_W = $clog2(HOLD_DEPTH + 1);

  // Backpressure statistics counter width
  localparam int unsigned STALL_CNT_W = 32;

endpackage

// File: rtl/frame_tx_hold_fifo.sv
// Small synchronous holding FIFO for RAM read data plus last flag.
module frame_tx_hold_fifo
  import frame_stream_tx_pkg::*;
#(
  parameter int unsigned WIDTH = 65
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head,
  output logic [HOLD_CNT_W-1:0] count
);

  logic [WIDTH-1:0]      mem_q [HOLD_DEPTH];
  logic [WIDTH-1:0]      mem_d [HOLD_DEPTH];
  logic [HOLD_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [HOLD_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [HOLD_CNT_W-1:0] count_q, count_d;

  // Pointer, occupancy and storage update
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + HOLD_CNT_W'(push) - HOLD_CNT_W'(pop);
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + HOLD_PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + HOLD_PTR_W'(1);
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(HOLD_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/frame_stream_tx.sv
// Frame stream transmitter: reads a frame from a synchronous sample RAM and
// emits it on a valid/ready stream with m_last on the final beat.
// Optional build macro FRAME_STREAM_TX_STALL_CNT_EN adds a stall_cnt port.
module frame_stream_tx
  import frame_stream_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [ADDR_WIDTH:0]    len,
  output logic                   busy,
  output logic                   done,
  output logic                   rd_en,
  output logic [ADDR_WIDTH-1:0]  rd_addr,
  input  logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_last
`ifdef FRAME_STREAM_TX_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  localparam int unsigned ENTRY_W = DATA_WIDTH + 1;
  localparam int unsigned LEN_W   = ADDR_WIDTH + 1;

  tx_state_e             state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [LEN_W-1:0]      reads_left_q, reads_left_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  m_last_q, m_last_d;

  logic [ENTRY_W-1:0]    fifo_head;
  logic [HOLD_CNT_W-1:0] fifo_count;
  logic [ENTRY_W-1:0]    src_entry_c;
  logic                  fifo_empty_c;
  logic                  out_load_c;
  logic                  take_c;
  logic                  fifo_push_c;
  logic                  fifo_pop_c;
  logic                  rd_issue_c;

  // Data steering: the output register takes the oldest pending beat, which is
  // the FIFO head, or the arriving RAM word directly when the FIFO is empty.
  assign fifo_empty_c = (fifo_count == '0);
  assign out_load_c   = !m_valid_q || m_ready;
  assign take_c       = out_load_c && (!fifo_empty_c || inflight_q);
  assign fifo_pop_c   = take_c && !fifo_empty_c;
  assign fifo_push_c  = inflight_q && !(take_c && fifo_empty_c);
  assign src_entry_c  = fifo_empty_c ? {inflight_last_q, rd_data} : fifo_head;

  // Read issue: keep at most two words buffered or in flight behind the output
  assign rd_issue_c = (state_q == ST_RUN) && (reads_left_q != '0) &&
                      ((3'(fifo_count) + 3'(inflight_q)) < (3'd2 + 3'(take_c)));

  frame_tx_hold_fifo #(
    .WIDTH (ENTRY_W)
  ) u_hold_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push_c),
    .push_data ({inflight_last_q, rd_data}),
    .pop       (fifo_pop_c),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  // Next-state, counters and output register
  always_comb begin
    state_d         = state_q;
    done_d          = 1'b0;
    rd_addr_d       = rd_addr_q;
    reads_left_d    = reads_left_q;
    inflight_d      = rd_issue_c;
    inflight_last_d = rd_issue_c && (reads_left_q == LEN_W'(1));
    m_valid_d       = m_valid_q;
    m_data_d        = m_data_q;
    m_last_d        = m_last_q;

    if (out_load_c) begin
      m_valid_d = take_c;
      if (take_c) begin
        m_data_d = src_entry_c[DATA_WIDTH-1:0];
        m_last_d = src_entry_c[DATA_WIDTH];
      end else begin
        m_last_d = 1'b0;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_d      = ST_RUN;
            rd_addr_d    = base_addr;
            reads_left_d = len;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (rd_issue_c) begin
          rd_addr_d    = rd_addr_q + ADDR_WIDTH'(1);
          reads_left_d = reads_left_q - LEN_W'(1);
          if (reads_left_q == LEN_W'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (m_valid_q && m_ready && m_last_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      rd_addr_q       <= '0;
      reads_left_q    <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      m_valid_q       <= 1'b0;
      m_data_q        <= '0;
      m_last_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      rd_addr_q       <= rd_addr_d;
      reads_left_q    <= reads_left_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      m_valid_q       <= m_valid_d;
      m_data_q        <= m_data_d;
      m_last_q        <= m_last_d;
    end
  end

`ifdef FRAME_STREAM_TX_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of busy cycles with a beat held by backpressure
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == ST_IDLE) && start) begin
      stall_cnt_d = '0;
    end else if (busy_q && m_valid_q && !m_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  // Stall counter register
  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_en   = rd_issue_c;
  assign rd_addr = rd_addr_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;

endmodule
